alarm_ctrl: RTL and testbench
=============================

# alarm_ctrl

Alarm controller downstream of the alarm setting register: compares the live time-of-day against the stored alarm time (`alarm_hours`/`alarm_minutes`) and runs the ring / snooze / stop sequence. It drives the buzzer and status outputs toward the display and speaker logic. All timing uses the one-second tick from the timekeeping counter.

## Interface

Parameters:
- `RING_TIMEOUT_S`, 60: seconds of ringing before automatic return to idle.
- `SNOOZE_S`, 300: seconds spent in snooze before ringing resumes.
- `MAX_SNOOZE`, 3: snoozes allowed per alarm event (1..3).

Ports:
- `sys_clk`  in  1  system clock. One clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sec_tick`  in  1  single-cycle pulse, once per second.
- `alarm_enable`  in  1  alarm on/off switch (level, already synchronized).
- `time_hours`  in  5  current hour, 0..23.
- `time_minutes`  in  6  current minute, 0..59.
- `alarm_hours`  in  5  stored alarm hour, 0..23.
- `alarm_minutes`  in  6  stored alarm minute, 0..59.
- `snooze_btn`  in  1  single-cycle pulse, debounced.
- `stop_btn`  in  1  single-cycle pulse, debounced.
- `alarm_ringing`  out  1  high while in RINGING.
- `buzzer`  out  1  beep pattern, 1 s on / 1 s off while ringing, else 0.
- `snooze_active`  out  1  high while in SNOOZE.
- `snoozes_left`  out  2  remaining snoozes for the current event.

## Operation

- `match` = (`time_hours`==`alarm_hours`) && (`time_minutes`==`alarm_minutes`). Combinational.
- `match_prev` is a register updated every cycle. Reset value is 1, so the reset-time 00:00==00:00 coincidence does not fire the alarm.
- `trigger` = `alarm_enable` && `match` && !`match_prev` && state==IDLE. The alarm fires on the rising edge of `match`. It fires once per matching minute and does not re-trigger after a stop within that minute.
- FSM states: IDLE, RINGING, SNOOZE.
  - IDLE -> RINGING on `trigger`. On this transition, load the ring counter with `RING_TIMEOUT_S`, load `snoozes_left` with `MAX_SNOOZE`, and set `buzzer` to 1.
  - RINGING -> SNOOZE on `snooze_btn` when `snoozes_left`>0. Load the snooze counter with `SNOOZE_S` and decrement `snoozes_left`. A `snooze_btn` pulse with `snoozes_left`==0 is ignored.
  - RINGING -> IDLE on `stop_btn`, or on `sec_tick` when the ring counter ==1 (timeout).
  - RINGING with `sec_tick` and no transition: decrement the ring counter and toggle `buzzer`.
  - SNOOZE -> RINGING on `sec_tick` when the snooze counter ==1. Reload the ring counter and set `buzzer` to 1. `snoozes_left` is not reloaded.
  - SNOOZE -> IDLE on `stop_btn`.
  - SNOOZE with `sec_tick` and no transition: decrement the snooze counter.
  - Any state -> IDLE when `alarm_enable`==0.
- Priority within one cycle, highest first: `alarm_enable` low, `stop_btn`, `snooze_btn`, `sec_tick` expiry/decrement. Example: snooze and timeout in the same cycle resolve to SNOOZE.
- Edits to `alarm_hours`/`alarm_minutes` while RINGING or SNOOZE do not affect the current event. A new `trigger` is only possible from IDLE.
- Arithmetic:
  - Ring counter width is $clog2(RING_TIMEOUT_S+1).
  - Snooze counter width is $clog2(SNOOZE_S+1).
  - Counters are unsigned, never decrement below 1, and do not wrap.

## Timing

- Reset values: state IDLE, `alarm_ringing`=0, `buzzer`=0, `snooze_active`=0, `snoozes_left`=0, `match_prev`=1, both counters 0.
- All outputs are registered.
- If `trigger` is true in cycle N, `alarm_ringing` and `buzzer` are 1 from cycle N+1.
- Ringing lasts exactly `RING_TIMEOUT_S` `sec_tick` pulses. Snooze lasts exactly `SNOOZE_S` pulses.
- Button response: the state change is visible one cycle after the pulse.
- `rst_n` asserted mid-ring or mid-snooze: all outputs clear immediately (asynchronously). After release the block is in IDLE and does not re-fire while `match` stays high.

## Structure

- Package `alarm_pkg` holds:
  - the state enum (IDLE, RINGING, SNOOZE);
  - `HOUR_MAX`=23 and `MIN_MAX`=59, shared with the alarm setting register and the timekeeping counter.
- Sub-module `sec_countdown` is a loadable down-counter with a width parameter.
  - Inputs: `load`, `load_val`, `tick`.
  - Output: `at_one` flag.
  - Instantiated twice: ring counter and snooze counter.

## Test plan

- Reset release with alarm 00:00, time 00:00, enable=1 -> no ring. Time advances to 00:01, alarm set to 00:01 -> no ring, because there is no rising edge.
- Alarm 06:30, time steps 06:29 -> 06:30, enable=1 -> `alarm_ringing`=1 one cycle later. `buzzer` toggles on each `sec_tick`. IDLE after 60 ticks.
- Ringing, `snooze_btn` -> `snooze_active`=1 and `snoozes_left`=2. After 300 ticks, ringing resumes. Repeat until `snoozes_left`=0; a fourth snooze is ignored.
- Ringing, `stop_btn` -> IDLE next cycle. Time stays 06:30 -> no re-trigger. Next day's 06:30 -> rings again.
- Same cycle: `snooze_btn`, `sec_tick`, and ring counter==1 -> SNOOZE. Same cycle: `stop_btn` and `snooze_btn` -> IDLE.
- `alarm_enable` dropped during SNOOZE -> IDLE and all outputs 0. `rst_n` pulsed during RINGING -> outputs 0 immediately and no re-fire.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared alarm-path types and time-of-day limits, common to the alarm setting
// register, the timekeeping counter and the alarm controller.
package alarm_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RINGING = 2'd1,
      SNOOZE  = 2'd2
   } alarm_state_e;

   localparam int HOUR_MAX = 23;
   localparam int MIN_MAX  = 59;

   // True when the live time equals the stored alarm time.
   function automatic logic time_match(input logic [4:0] th, input logic [5:0] tm,
                                       input logic [4:0] ah, input logic [5:0] am);
      return (th == ah) && (tm == am);
   endfunction

endpackage

// File: rtl/sec_countdown.sv
// Loadable seconds down-counter: holds at 1 rather than wrapping, and flags
// when it sits at 1 so the owner knows the next tick is the last one.
module sec_countdown #(
   parameter int W = 6
) (
   input  logic         sys_clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         tick,
   output logic         at_one
);

   logic [W-1:0] count_q;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (tick && (count_q > W'(1))) begin
         count_q <= count_q - W'(1);
      end
   end

   assign at_one = (count_q == W'(1));

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: fires on the rising edge of time==alarm and sequences
// ring / snooze / stop, driving the buzzer beep and status outputs.
module alarm_ctrl
   import alarm_pkg::*;
#(
   parameter int RING_TIMEOUT_S = 60,
   parameter int SNOOZE_S       = 300,
   parameter int MAX_SNOOZE     = 3
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic       sec_tick,
   input  logic       alarm_enable,
   input  logic [4:0] time_hours,
   input  logic [5:0] time_minutes,
   input  logic [4:0] alarm_hours,
   input  logic [5:0] alarm_minutes,
   input  logic       snooze_btn,
   input  logic       stop_btn,
   output logic       alarm_ringing,
   output logic       buzzer,
   output logic       snooze_active,
   output logic [1:0] snoozes_left
);

   localparam int RW = $clog2(RING_TIMEOUT_S + 1);
   localparam int SW = $clog2(SNOOZE_S + 1);

   alarm_state_e state_q, state_d;
   logic         buzzer_q, buzzer_d;
   logic [1:0]   snz_left_q, snz_left_d;
   logic         ringing_q, snoozing_q;
   logic         match_prev_q;
   logic         match, trigger;
   logic         ring_load, ring_dec, ring_at_one;
   logic         snz_load, snz_dec, snz_at_one;

   assign match   = time_match(time_hours, time_minutes, alarm_hours, alarm_minutes);
   assign trigger = alarm_enable && match && !match_prev_q && (state_q == IDLE);

   sec_countdown #(.W(RW)) u_ring_cnt (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .load     (ring_load),
      .load_val (RW'(RING_TIMEOUT_S)),
      .tick     (ring_dec),
      .at_one   (ring_at_one)
   );

   sec_countdown #(.W(SW)) u_snooze_cnt (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .load     (snz_load),
      .load_val (SW'(SNOOZE_S)),
      .tick     (snz_dec),
      .at_one   (snz_at_one)
   );

   // Priority: enable low, then stop, then snooze, then the second tick.
   always_comb begin
      state_d    = state_q;
      buzzer_d   = buzzer_q;
      snz_left_d = snz_left_q;
      ring_load  = 1'b0;
      ring_dec   = 1'b0;
      snz_load   = 1'b0;
      snz_dec    = 1'b0;
      if (!alarm_enable) begin
         state_d    = IDLE;
         buzzer_d   = 1'b0;
         snz_left_d = 2'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (trigger) begin
                  state_d    = RINGING;
                  ring_load  = 1'b1;
                  snz_left_d = 2'(MAX_SNOOZE);
                  buzzer_d   = 1'b1;
               end
            end
            RINGING: begin
               if (stop_btn) begin
                  state_d    = IDLE;
                  buzzer_d   = 1'b0;
                  snz_left_d = 2'd0;
               end else if (snooze_btn && (snz_left_q != 2'd0)) begin
                  state_d    = SNOOZE;
                  snz_load   = 1'b1;
                  snz_left_d = snz_left_q - 2'd1;
                  buzzer_d   = 1'b0;
               end else if (sec_tick) begin
                  if (ring_at_one) begin
                     state_d    = IDLE;
                     buzzer_d   = 1'b0;
                     snz_left_d = 2'd0;
                  end else begin
                     ring_dec = 1'b1;
                     buzzer_d = ~buzzer_q;
                  end
               end
            end
            SNOOZE: begin
               if (stop_btn) begin
                  state_d    = IDLE;
                  buzzer_d   = 1'b0;
                  snz_left_d = 2'd0;
               end else if (sec_tick) begin
                  if (snz_at_one) begin
                     state_d   = RINGING;
                     ring_load = 1'b1;
                     buzzer_d  = 1'b1;
                  end else begin
                     snz_dec = 1'b1;
                  end
               end
            end
            default: begin
               state_d    = IDLE;
               buzzer_d   = 1'b0;
               snz_left_d = 2'd0;
            end
         endcase
      end
   end

   // match_prev resets high so the 00:00==00:00 coincidence after reset is not an edge.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         buzzer_q     <= 1'b0;
         snz_left_q   <= 2'd0;
         ringing_q    <= 1'b0;
         snoozing_q   <= 1'b0;
         match_prev_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         buzzer_q     <= buzzer_d;
         snz_left_q   <= snz_left_d;
         ringing_q    <= (state_d == RINGING);
         snoozing_q   <= (state_d == SNOOZE);
         match_prev_q <= match;
      end
   end

   assign alarm_ringing = ringing_q;
   assign buzzer        = buzzer_q;
   assign snooze_active = snoozing_q;
   assign snoozes_left  = snz_left_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: directed scenarios plus random traffic, checked
// cycle by cycle against a seconds-remaining model of the alarm behaviour.
module tb_alarm_ctrl;

   localparam int RT = 60;
   localparam int SZ = 300;
   localparam int MS = 3;

   logic       sys_clk = 1'b0;
   logic       rst_n;
   logic       sec_tick, alarm_enable, snooze_btn, stop_btn;
   logic [4:0] time_hours, alarm_hours;
   logic [5:0] time_minutes, alarm_minutes;
   logic       alarm_ringing, buzzer, snooze_active;
   logic [1:0] snoozes_left;

   logic [4:0] exp_q[$];
   int         n_cmp = 0;
   int         n_err = 0;

   // Model: phase 0 idle / 1 ringing / 2 snoozing, plus seconds remaining.
   int m_phase, m_ring_left, m_snz_left, m_snoozes;
   bit m_prev;

   always #5 sys_clk = ~sys_clk;

   alarm_ctrl #(
      .RING_TIMEOUT_S (RT),
      .SNOOZE_S       (SZ),
      .MAX_SNOOZE     (MS)
   ) dut (
      .sys_clk       (sys_clk),
      .rst_n         (rst_n),
      .sec_tick      (sec_tick),
      .alarm_enable  (alarm_enable),
      .time_hours    (time_hours),
      .time_minutes  (time_minutes),
      .alarm_hours   (alarm_hours),
      .alarm_minutes (alarm_minutes),
      .snooze_btn    (snooze_btn),
      .stop_btn      (stop_btn),
      .alarm_ringing (alarm_ringing),
      .buzzer        (buzzer),
      .snooze_active (snooze_active),
      .snoozes_left  (snoozes_left)
   );

   function automatic void m_reset();
      m_phase     = 0;
      m_ring_left = 0;
      m_snz_left  = 0;
      m_snoozes   = 0;
      m_prev      = 1'b1;
   endfunction

   // Buzzer is on for even elapsed seconds of the current ring period.
   function automatic logic [4:0] m_expect();
      logic ring, buzz, snz;
      ring = (m_phase == 1);
      buzz = ring && (((RT - m_ring_left) % 2) == 0);
      snz  = (m_phase == 2);
      return {ring, buzz, snz, 2'(m_snoozes)};
   endfunction

   function automatic void m_step();
      bit match;
      match = (time_hours == alarm_hours) && (time_minutes == alarm_minutes);
      if (!rst_n) begin
         m_reset();
         return;
      end
      if (!alarm_enable) begin
         m_phase   = 0;
         m_snoozes = 0;
      end else if (m_phase == 0) begin
         if (match && !m_prev) begin
            m_phase     = 1;
            m_ring_left = RT;
            m_snoozes   = MS;
         end
      end else if (m_phase == 1) begin
         if (stop_btn) begin
            m_phase   = 0;
            m_snoozes = 0;
         end else if (snooze_btn && m_snoozes > 0) begin
            m_phase    = 2;
            m_snz_left = SZ;
            m_snoozes  = m_snoozes - 1;
         end else if (sec_tick) begin
            m_ring_left = m_ring_left - 1;
            if (m_ring_left == 0) begin
               m_phase   = 0;
               m_snoozes = 0;
            end
         end
      end else begin
         if (stop_btn) begin
            m_phase   = 0;
            m_snoozes = 0;
         end else if (sec_tick) begin
            m_snz_left = m_snz_left - 1;
            if (m_snz_left == 0) begin
               m_phase     = 1;
               m_ring_left = RT;
            end
         end
      end
      m_prev = match;
   endfunction

   // Monitor: one expected output word per clock, compared mid-cycle.
   always @(negedge sys_clk) begin
      logic [4:0] e, got;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         got = {alarm_ringing, buzzer, snooze_active, snoozes_left};
         n_cmp++;
         if (got !== e) begin
            n_err++;
            $display("FAIL outputs t=%0t: got %b required %b (ring,buzz,snz,left[1:0])",
                     $time, got, e);
         end
      end
   end

   task automatic check_now(input string name, input logic [4:0] e);
      logic [4:0] got;
      got = {alarm_ringing, buzzer, snooze_active, snoozes_left};
      n_cmp++;
      if (got !== e) begin
         n_err++;
         $display("FAIL %s t=%0t: got %b required %b", name, $time, got, e);
      end
   endtask

   task automatic cycle(input logic t, input logic s, input logic p);
      sec_tick   = t;
      snooze_btn = s;
      stop_btn   = p;
      m_step();
      @(posedge sys_clk);
      exp_q.push_back(m_expect());
      #1;
      sec_tick   = 1'b0;
      snooze_btn = 1'b0;
      stop_btn   = 1'b0;
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         idle_n($urandom_range(0, 2));
         cycle(1'b1, 1'b0, 1'b0);
      end
   endtask

   task automatic set_time(input int h, input int m);
      time_hours   = 5'(h);
      time_minutes = 6'(m);
   endtask

   // Leave 06:30 for a cycle and come back: a fresh rising edge of match.
   task automatic retrigger();
      set_time(6, 31);
      idle_n(2);
      set_time(6, 30);
      idle_n(2);
   endtask

   task automatic async_reset_pulse();
      @(negedge sys_clk);
      #1;
      rst_n = 1'b0;
      m_reset();
      #1;
      check_now("async_reset", 5'b0);
      idle_n(3);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n        = 1'b0;
      alarm_enable = 1'b1;
      sec_tick     = 1'b0;
      snooze_btn   = 1'b0;
      stop_btn     = 1'b0;
      set_time(0, 0);
      alarm_hours   = 5'd0;
      alarm_minutes = 6'd0;
      m_reset();
      #1;
      check_now("reset_state", 5'b0);
      idle_n(3);
      rst_n = 1'b1;

      // 00:00 coincidence at reset release, then both move together: no edge.
      idle_n(5);
      set_time(0, 1);
      alarm_minutes = 6'd1;
      idle_n(4);
      ticks(3);

      // Normal fire at 06:30 and ring out to timeout; no refire in same minute.
      alarm_hours   = 5'd6;
      alarm_minutes = 6'd30;
      set_time(6, 29);
      idle_n(3);
      set_time(6, 30);
      idle_n(2);
      ticks(RT + 3);

      // Snooze all three, fourth ignored, then stop; still 06:30 so no refire.
      retrigger();
      for (int k = 0; k < MS; k++) begin
         ticks(2);
         cycle(1'b0, 1'b1, 1'b0);
         ticks(SZ);
      end
      cycle(1'b0, 1'b1, 1'b0);
      ticks(4);
      cycle(1'b0, 1'b0, 1'b1);
      idle_n(5);

      // Snooze coinciding with the final ring tick wins; stop beats snooze.
      retrigger();
      ticks(RT - 1);
      cycle(1'b1, 1'b1, 1'b0);
      ticks(SZ);
      idle_n(2);
      cycle(1'b0, 1'b1, 1'b1);
      idle_n(3);

      // Enable dropped while snoozing, re-enabled with match still high.
      retrigger();
      cycle(1'b0, 1'b1, 1'b0);
      ticks(10);
      alarm_enable = 1'b0;
      idle_n(3);
      alarm_enable = 1'b1;
      idle_n(3);

      // Alarm edited mid-ring does not disturb the event.
      retrigger();
      alarm_hours = 5'd7;
      alarm_minutes = 6'd0;
      ticks(5);
      cycle(1'b0, 1'b0, 1'b1);
      alarm_hours = 5'd6;
      alarm_minutes = 6'd30;
      idle_n(2);
      ticks(3);
      cycle(1'b0, 1'b0, 1'b1);

      // Reset pulse mid-ring: outputs clear at once, no refire afterwards.
      retrigger();
      ticks(4);
      async_reset_pulse();
      idle_n(6);
      ticks(2);

      // Random traffic around the alarm time.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            if ($urandom_range(0, 1) == 0) set_time(alarm_hours, alarm_minutes);
            else set_time($urandom_range(0, 23), $urandom_range(0, 59));
         end
         if ($urandom_range(0, 299) == 0) begin
            alarm_hours   = 5'($urandom_range(0, 23));
            alarm_minutes = 6'($urandom_range(0, 59));
         end
         if (alarm_enable && $urandom_range(0, 399) == 0) alarm_enable = 1'b0;
         else if (!alarm_enable && $urandom_range(0, 7) == 0) alarm_enable = 1'b1;
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0),
               1'($urandom_range(0, 79) == 0));
      end

      @(negedge sys_clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
